// File: rtl/demux8_frame.sv
// Serial-to-parallel frame demultiplexer: collects eight channel words (a..h)
// into one parallel frame with a valid/ready output handshake.
module demux8_frame #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_start,
  output logic                 in_ready,
  output logic [2:0]           sel,
  output logic [8*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err
);

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned SHADOW_W = (NUM_CH - 1) * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic [8*WIDTH-1:0]    out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  accept;

  // A new word may enter whenever the output slot is empty or being drained.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign sel       = (state_q == COLLECT) ? cnt_q : '0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;

    // Consumer drained the frame; a completion below may refill it this cycle.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_start) begin
            shadow_d[0 +: WIDTH] = in_data;
            cnt_d                = CNT_W'(1);
            state_d              = COLLECT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (accept) begin
          if (in_start) begin
            // Restart: drop the partial frame, this word becomes channel a.
            frame_err_d          = 1'b1;
            shadow_d[0 +: WIDTH] = in_data;
            cnt_d                = CNT_W'(1);
          end else if (cnt_q == LAST_CH) begin
            out_data_d  = {in_data, shadow_q};
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            for (int unsigned k = 0; k < NUM_CH - 1; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                shadow_d[k*WIDTH +: WIDTH] = in_data;
              end
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_demux8_frame.sv
// Scoreboard bench for demux8_frame: directed frames plus randomized traffic
// checked against a queue-based frame model.
module tb_demux8_frame;

  localparam int unsigned W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_start;
  logic            in_ready;
  logic [2:0]      sel;
  logic [8*W-1:0]  out_data;
  logic            out_valid;
  logic            out_ready;
  logic            frame_err;

  demux8_frame #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state
  logic [W-1:0]   partial[$];
  logic [8*W-1:0] exp_q[$];
  logic           exp_ov     = 1'b0;
  logic           exp_err    = 1'b0;
  logic           chk_zero   = 1'b0;
  logic           started    = 1'b0;
  logic [8*W-1:0] last_frame = '0;
  int unsigned    n_frames   = 0;
  int unsigned    dut_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model: compare current outputs, then predict the next edge.
  always @(negedge clk) begin
    logic           acc;
    logic [8*W-1:0] f;
    if (started) begin
      check("in_ready", 32'(in_ready), 32'(!exp_ov || out_ready));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("frame_err", 32'(frame_err), 32'(exp_err));
      check("sel", 32'(sel), 32'(partial.size()));
      if (out_valid && exp_ov) begin
        if (exp_q.size() == 0) check("out_data_unexpected", 32'(out_data), 32'hxxxxxxxx);
        else check("out_data", 32'(out_data), 32'(exp_q[0]));
      end
      if (chk_zero) begin
        check("out_data_reset", 32'(out_data), 32'h0);
        chk_zero = 1'b0;
      end
      if (frame_err === 1'b1) dut_errs++;
    end
    if (rst) begin
      partial.delete();
      exp_q.delete();
      exp_ov   = 1'b0;
      exp_err  = 1'b0;
      chk_zero = 1'b1;
      started  = 1'b1;
    end else begin
      exp_err = 1'b0;
      acc = in_valid && (!exp_ov || out_ready);
      if (exp_ov && out_ready) begin
        last_frame = exp_q.pop_front();
        n_frames++;
        exp_ov = 1'b0;
      end
      if (acc) begin
        if (in_start) begin
          if (partial.size() != 0) exp_err = 1'b1;
          partial.delete();
          partial.push_back(in_data);
        end else if (partial.size() == 0) begin
          exp_err = 1'b1;
        end else begin
          partial.push_back(in_data);
          if (partial.size() == 8) begin
            f = '0;
            for (int k = 0; k < 8; k++) f[k*W +: W] = partial[k];
            exp_q.push_back(f);
            exp_ov = 1'b1;
            partial.delete();
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a word until accepted; must be called just after a rising edge.
  task automatic send(input logic [W-1:0] d, input logic s);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_start = s;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accepted", 32'(acc), 32'h1);
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] first);
    for (int i = 0; i < 8; i++) send(W'(first + W'(i)), i == 0);
  endtask

  initial begin
    int unsigned e0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_start = 1'b0; out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);

    // Back-to-back frame 1..8
    send_frame(W'(1));
    check("b2b_valid", 32'(out_valid), 32'h1);
    check("b2b_data", 32'(out_data), 32'h87654321);
    tick(1);
    check("b2b_valid_one_cycle", 32'(out_valid), 32'h0);
    check("b2b_last", 32'(last_frame), 32'h87654321);

    // Gap of three idle cycles after word 4
    for (int i = 1; i <= 4; i++) send(W'(i), i == 1);
    for (int i = 0; i < 3; i++) begin
      check("gap_sel", 32'(sel), 32'h4);
      tick(1);
    end
    for (int i = 5; i <= 8; i++) send(W'(i), 1'b0);
    tick(1);
    check("gap_last", 32'(last_frame), 32'h87654321);

    // Backpressure: held frame stays, second frame waits for release
    out_ready = 1'b0;
    send_frame(W'(1));
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'(9 + i), i == 0);
      end
      begin
        tick(4);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        check("bp_hold", 32'(out_data), 32'h87654321);
        check("bp_sel", 32'(sel), 32'h0);
        out_ready = 1'b1;
      end
    join
    tick(1);
    check("bp_second", 32'(last_frame), 32'h0FEDCBA9);

    // Restart on word 5
    e0 = dut_errs;
    for (int i = 1; i <= 4; i++) send(W'(i), i == 1);
    send(W'(5), 1'b1);
    check("restart_err", 32'(frame_err), 32'h1);
    check("restart_sel", 32'(sel), 32'h1);
    for (int i = 6; i <= 12; i++) send(W'(i), 1'b0);
    tick(1);
    check("restart_err_count", dut_errs - e0, 32'h1);
    check("restart_frame", 32'(last_frame), 32'hCBA98765);

    // Word without start in IDLE
    send(W'(3), 1'b0);
    check("idle_err", 32'(frame_err), 32'h1);
    check("idle_sel", 32'(sel), 32'h0);
    check("idle_no_valid", 32'(out_valid), 32'h0);
    tick(1);

    // Reset mid-frame, then clean frame 9..F,0
    e0 = dut_errs;
    for (int i = 1; i <= 6; i++) send(W'(i), i == 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_sel", 32'(sel), 32'h0);
    send_frame(W'(9));
    tick(1);
    check("midrst_no_err", dut_errs - e0, 32'h0);
    check("midrst_frame", 32'(last_frame), 32'h0FEDCBA9);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = W'($urandom);
      in_start  = (partial.size() == 0) ? (($urandom % 4) != 0) : (($urandom % 20) == 0);
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 500) == 0;
      tick(1);
    end
    in_valid = 1'b0; in_start = 1'b0; rst = 1'b0; out_ready = 1'b1;
    tick(4);
    check("drain", 32'(exp_q.size()), 32'h0);
    check("random_frames_seen", 32'(n_frames > 20), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
